// File: rtl/ddr2_fifo_pkg.sv
// Shared constants for the DDR2 host command FIFO.
// The FIFO RTL imports this package. The flow-control checker and the host
// driver also import it, so that every block agrees on depth and threshold.
package ddr2_fifo_pkg;
  localparam int DATA_W      = 32;  // command + address + tag
  localparam int DEPTH       = 64;  // physical entries, power of two
  localparam int PTR_W       = 6;   // log2(DEPTH)
  localparam int CNT_W       = 7;   // holds 0..DEPTH
  localparam int FULL_THRESH = 33;  // notfull drops at or above this count
endpackage

// File: rtl/ddr2_fifo_ram.sv
// Storage array for the DDR2 command FIFO: DEPTH x DATA_W entries.
// Ports:
//   clk   - write clock
//   we    - write enable (already qualified by the caller)
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - asynchronous read data (mem[raddr])
// The contents are not reset.
module ddr2_fifo_ram
  import ddr2_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ddr2_cmd_fifo_flow.sv
// Host-side command FIFO for the DDR2 front end. It presents the host
// flow-control contract (fillcount / notfull), and the command scheduler
// drains it.
// Ports:
//   clk, reset             - single clock, synchronous active-high reset
//   wr_en, wr_data         - host push
//   notfull                - 1 while fillcount < FULL_THRESH
//   fillcount              - stored entries, 0..DEPTH
//   rd_en                  - scheduler pop of the head entry
//   rd_data, rd_valid      - show-ahead head entry; rd_data is 0 when empty
//   overflow, underflow    - sticky error flags, cleared only by reset
//   high_water             - largest fillcount seen since reset
// notfull drops well below physical depth. The entries above FULL_THRESH
// absorb pushes that a pipelined host already has in flight.
module ddr2_cmd_fifo_flow
  import ddr2_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              notfull,
  output logic [CNT_W-1:0]  fillcount,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  high_water
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FULL_THRESH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  hw;
  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] ram_rdata;

  // Accept decisions use the pre-edge count. A same-cycle pop therefore
  // never makes room for a push at DEPTH, and a same-cycle push never
  // supplies data for a pop from an empty FIFO.
  always_comb begin
    push_ok   = wr_en && (count < DEPTH_C);
    pop_ok    = rd_en && (count != '0);
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      hw        <= '0;
    end else begin
      // Pointers wrap naturally. Full and empty are resolved by count.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (wr_en && (count == DEPTH_C)) overflow  <= 1'b1;
      if (rd_en && (count == '0))      underflow <= 1'b1;
      if (count_nxt > hw)              hw        <= count_nxt;
    end
  end

  // Reset takes priority over a same-cycle push, so the RAM write is also
  // blocked during reset.
  ddr2_fifo_ram u_ram (
    .clk   (clk),
    .we    (push_ok && !reset),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign fillcount  = count;
  assign notfull    = (count < THRESH_C);
  assign rd_valid   = (count != '0);
  assign rd_data    = (count == '0) ? '0 : ram_rdata;
  assign high_water = hw;

endmodule

// File: tb/tb_ddr2_cmd_fifo_flow.sv
module tb_ddr2_cmd_fifo_flow;
  import ddr2_fifo_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic              notfull;
  logic [CNT_W-1:0]  fillcount;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  high_water;

  ddr2_cmd_fifo_flow dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .notfull    (notfull),
    .fillcount  (fillcount),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .overflow   (overflow),
    .underflow  (underflow),
    .high_water (high_water)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a queue of stored entries plus the flag and high-water state.
  logic [DATA_W-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  int   m_hw  = 0;

  function automatic logic [DATA_W-1:0] m_head();
    return (q.size() == 0) ? '0 : q[0];
  endfunction

  task automatic model_step(input logic w, input logic [DATA_W-1:0] d,
                            input logic r, input logic rs);
    int pre;
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_hw  = 0;
    end else begin
      pre = q.size();
      if (w && pre == DEPTH) m_ovf = 1'b1;
      if (r && pre == 0)     m_unf = 1'b1;
      if (r && pre != 0)     void'(q.pop_front());
      if (w && pre < DEPTH)  q.push_back(d);
      if (q.size() > m_hw)   m_hw = q.size();
    end
  endtask

  // Apply one cycle of inputs, advance the model, and settle 1 time unit after the edge.
  task automatic tick(input logic w, input logic [DATA_W-1:0] d,
                      input logic r, input logic rs);
    wr_en = w; wr_data = d; rd_en = r; reset = rs;
    @(posedge clk);
    model_step(w, d, r, rs);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 1'b0, 1'b1);
    compared++; if (fillcount !== 7'd0) begin mismatched++; $display("FAIL reset_fill got %0d want 0", fillcount); end
    compared++; if (notfull !== 1'b1) begin mismatched++; $display("FAIL reset_notfull got %b want 1", notfull); end
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    compared++; if (rd_data !== 32'h0) begin mismatched++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    compared++; if ({overflow, underflow} !== 2'b00) begin mismatched++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
    compared++; if (high_water !== 7'd0) begin mismatched++; $display("FAIL reset_high_water got %0d want 0", high_water); end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 32; i++) tick(1'b1, 32'h1000 + i, 1'b0, 1'b0);
    compared++; if (fillcount !== 7'd32) begin mismatched++; $display("FAIL thr_fill32 got %0d want 32", fillcount); end
    compared++; if (notfull !== 1'b1) begin mismatched++; $display("FAIL thr_notfull32 got %b want 1", notfull); end
    tick(1'b1, 32'h1020, 1'b0, 1'b0);
    compared++; if (fillcount !== 7'd33) begin mismatched++; $display("FAIL thr_fill33 got %0d want 33", fillcount); end
    compared++; if (notfull !== 1'b0) begin mismatched++; $display("FAIL thr_notfull33 got %b want 0", notfull); end
    compared++; if (rd_data !== 32'h1000) begin mismatched++; $display("FAIL thr_head got %h want 00001000", rd_data); end
  endtask

  task automatic test_overflow_drain();
    for (int i = 33; i < 64; i++) tick(1'b1, 32'h1000 + i, 1'b0, 1'b0);
    compared++; if (fillcount !== 7'd64) begin mismatched++; $display("FAIL ovf_fill64 got %0d want 64", fillcount); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_slack_flag got %b want 0", overflow); end
    tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    compared++; if (fillcount !== 7'd64) begin mismatched++; $display("FAIL ovf_fill_hold got %0d want 64", fillcount); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < 64; i++) begin
      compared++;
      if (rd_data !== 32'h1000 + i) begin
        mismatched++; $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, 32'h1000 + i);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL drain_rd_valid got %b want 0", rd_valid); end
    compared++; if (rd_data !== 32'h0) begin mismatched++; $display("FAIL drain_rd_data got %h want 0", rd_data); end
    compared++; if (underflow !== 1'b0) begin mismatched++; $display("FAIL drain_underflow got %b want 0", underflow); end
    compared++; if (high_water !== 7'd64) begin mismatched++; $display("FAIL drain_high_water got %0d want 64", high_water); end
  endtask

  task automatic test_steady_33();
    logic [DATA_W-1:0] want;
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) tick(1'b1, 32'h2000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      want = 32'h2000 + i;
      compared++;
      if (rd_data !== want) begin
        mismatched++; $display("FAIL steady_data[%0d] got %h want %h", i, rd_data, want);
      end
      tick(1'b1, 32'h2000 + 33 + i, 1'b1, 1'b0);
      compared++;
      if (fillcount !== 7'd33 || notfull !== 1'b0) begin
        mismatched++; $display("FAIL steady_fill[%0d] got %0d/%b want 33/0", i, fillcount, notfull);
      end
    end
    compared++; if (rd_data !== 32'h2000 + 100) begin mismatched++; $display("FAIL steady_head got %h want %h", rd_data, 32'h2000 + 100); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 31; i++) tick(1'b1, 32'h3000 + i, 1'b0, 1'b0);
    compared++; if (fillcount !== 7'd64) begin mismatched++; $display("FAIL fpp_fill64 got %0d want 64", fillcount); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL fpp_pre_flag got %b want 0", overflow); end
    tick(1'b1, 32'hBAD0_0001, 1'b1, 1'b0);
    compared++; if (fillcount !== 7'd63) begin mismatched++; $display("FAIL fpp_fill got %0d want 63", fillcount); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL fpp_overflow got %b want 1", overflow); end
    compared++; if (rd_data !== m_head()) begin mismatched++; $display("FAIL fpp_head got %h want %h", rd_data, m_head()); end
  endtask

  task automatic test_empty_push_pop();
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_ABCD, 1'b1, 1'b0);
    compared++; if (underflow !== 1'b1) begin mismatched++; $display("FAIL epp_underflow got %b want 1", underflow); end
    compared++; if (fillcount !== 7'd1) begin mismatched++; $display("FAIL epp_fill got %0d want 1", fillcount); end
    compared++; if (rd_data !== 32'h0000_ABCD || rd_valid !== 1'b1) begin mismatched++; $display("FAIL epp_data got %h/%b want 0000abcd/1", rd_data, rd_valid); end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);  // sets underflow so reset has a flag to clear
    for (int i = 0; i < 40; i++) tick(1'b1, 32'h4000 + i, 1'b0, 1'b0);
    compared++; if (fillcount !== 7'd40) begin mismatched++; $display("FAIL rm_fill40 got %0d want 40", fillcount); end
    tick(1'b1, 32'h4444_4444, 1'b0, 1'b1);
    compared++; if (fillcount !== 7'd0 || notfull !== 1'b1) begin mismatched++; $display("FAIL rm_fill got %0d/%b want 0/1", fillcount, notfull); end
    compared++; if (high_water !== 7'd0) begin mismatched++; $display("FAIL rm_high_water got %0d want 0", high_water); end
    compared++; if ({overflow, underflow} !== 2'b00) begin mismatched++; $display("FAIL rm_flags got %b want 00", {overflow, underflow}); end
    tick(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
    compared++; if (rd_data !== 32'h5A5A_5A5A || fillcount !== 7'd1) begin mismatched++; $display("FAIL rm_readback got %h/%0d want 5a5a5a5a/1", rd_data, fillcount); end
  endtask

  task automatic test_random();
    int wp, rp;
    logic w, r, rs;
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      // Rotate bias phases so the run fills to overflow and drains to underflow.
      case ((i / 250) % 4)
        0: begin wp = 90; rp = 20; end
        1: begin wp = 50; rp = 50; end
        2: begin wp = 15; rp = 90; end
        default: begin wp = 70; rp = 60; end
      endcase
      w  = ($urandom_range(99) < wp);
      r  = ($urandom_range(99) < rp);
      rs = ($urandom_range(399) == 0);
      tick(w, $urandom, r, rs);
      compared++;
      if (fillcount !== q.size() || notfull !== (q.size() < FULL_THRESH) ||
          rd_valid !== (q.size() != 0) || rd_data !== m_head() ||
          overflow !== m_ovf || underflow !== m_unf || high_water !== m_hw) begin
        mismatched++;
        $display("FAIL rand[%0d] got fc=%0d nf=%b rv=%b rd=%h ov=%b un=%b hw=%0d want fc=%0d nf=%b rv=%b rd=%h ov=%b un=%b hw=%0d",
                 i, fillcount, notfull, rd_valid, rd_data, overflow, underflow, high_water,
                 q.size(), (q.size() < FULL_THRESH), (q.size() != 0), m_head(), m_ovf, m_unf, m_hw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_overflow_drain();
    test_steady_33();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
